// File: rtl/pio_master_pkg.sv
// Shared types and constants for the PIO register-access initiator.
package pio_master_pkg;

  localparam logic [31:0] PIO_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT,
    DONE
  } pio_mst_state_e;

endpackage

// File: rtl/pio_timeout_cnt.sv
// Response-timeout counter: cleared on entry to a wait, counts enabled beats,
// flags expiry on the beat where the count reaches LIMIT-1.
module pio_timeout_cnt #(
  parameter int NBITS = 12,
  parameter int LIMIT = 2048
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [NBITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == NBITS'(LIMIT - 1));

endmodule

// File: rtl/pio_master.sv
// PIO bus initiator: turns one host register access at a time into
// start/address/data beats and waits for ack, rvalid or a timeout.
module pio_master
  import pio_master_pkg::*;
#(
  parameter int                   PIO_NBITS      = 32,
  parameter int                   TIMEOUT_NBITS  = 12,
  parameter int                   TIMEOUT_CYCLES = 2048,
  parameter logic [PIO_NBITS-1:0] ERR_RDATA      = PIO_ERR_RDATA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_div,
  input  logic                 host_req,
  input  logic                 host_rw,
  input  logic [PIO_NBITS-1:0] host_addr,
  input  logic [PIO_NBITS-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_done,
  output logic [PIO_NBITS-1:0] host_rdata,
  output logic                 host_err,
  output logic                 busy,
  output logic                 pio_start,
  output logic                 pio_rw,
  output logic [PIO_NBITS-1:0] pio_addr_wdata,
  input  logic                 pio_ack,
  input  logic                 pio_rvalid,
  input  logic [PIO_NBITS-1:0] pio_rdata
);

  pio_mst_state_e       state_q;
  logic                 rw_q;
  logic [PIO_NBITS-1:0] addr_q;
  logic [PIO_NBITS-1:0] wdata_q;
  logic                 host_gnt_q;
  logic                 host_done_q;
  logic [PIO_NBITS-1:0] host_rdata_q;
  logic                 host_err_q;
  logic                 busy_q;
  logic                 pio_start_q;
  logic                 pio_rw_q;
  logic [PIO_NBITS-1:0] pio_ad_q;
  logic                 tmo_clr;
  logic                 tmo_en;
  logic                 tmo_expire;
  logic                 resp_hit;

  // The counter restarts on the beat that moves the FSM into WAIT.
  assign tmo_clr  = clk_div && (((state_q == ADDR) && rw_q) || (state_q == DATA));
  assign tmo_en   = clk_div && (state_q == WAIT);
  assign resp_hit = rw_q ? pio_rvalid : pio_ack;

  pio_timeout_cnt #(
    .NBITS(TIMEOUT_NBITS),
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (tmo_clr),
    .en_i    (tmo_en),
    .expire_o(tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      host_gnt_q   <= 1'b0;
      host_done_q  <= 1'b0;
      host_rdata_q <= '0;
      host_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      pio_start_q  <= 1'b0;
      pio_rw_q     <= 1'b0;
      pio_ad_q     <= '0;
    end else begin
      host_gnt_q  <= 1'b0;
      host_done_q <= 1'b0;
      pio_start_q <= 1'b0;
      pio_rw_q    <= 1'b0;
      pio_ad_q    <= '0;
      busy_q      <= (state_q == ADDR) || (state_q == DATA) || (state_q == WAIT);
      case (state_q)
        // DONE accepts directly so a held request is granted the next cycle.
        IDLE, DONE: begin
          if (host_req) begin
            host_gnt_q <= 1'b1;
            rw_q       <= host_rw;
            addr_q     <= host_addr;
            wdata_q    <= host_wdata;
            state_q    <= ADDR;
          end else begin
            state_q <= IDLE;
          end
        end
        ADDR: begin
          if (clk_div) begin
            pio_start_q <= 1'b1;
            pio_rw_q    <= rw_q;
            pio_ad_q    <= addr_q;
            state_q     <= rw_q ? WAIT : DATA;
          end
        end
        DATA: begin
          if (clk_div) begin
            pio_ad_q <= wdata_q;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (resp_hit) begin
            host_done_q  <= 1'b1;
            host_err_q   <= 1'b0;
            host_rdata_q <= rw_q ? pio_rdata : '0;
            state_q      <= DONE;
          end else if (tmo_expire) begin
            host_done_q  <= 1'b1;
            host_err_q   <= 1'b1;
            host_rdata_q <= rw_q ? ERR_RDATA : '0;
            state_q      <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_gnt       = host_gnt_q;
  assign host_done      = host_done_q;
  assign host_rdata     = host_rdata_q;
  assign host_err       = host_err_q;
  assign busy           = busy_q;
  assign pio_start      = pio_start_q;
  assign pio_rw         = pio_rw_q;
  assign pio_addr_wdata = pio_ad_q;

endmodule

// File: tb/tb_pio_master.sv
// Bench for pio_master: directed vector table, randomized transactions against
// a cycle-level protocol model, back-to-back and reset-abort sequences.
module tb_pio_master;

  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int          BUDGET = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_div;
  logic        host_req;
  logic        host_rw;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_done;
  logic [31:0] host_rdata;
  logic        host_err;
  logic        busy;
  logic        pio_start;
  logic        pio_rw;
  logic [31:0] pio_addr_wdata;
  logic        pio_ack;
  logic        pio_rvalid;
  logic [31:0] pio_rdata;

  int total = 0;
  int bad   = 0;

  pio_master #(
    .PIO_NBITS     (32),
    .TIMEOUT_NBITS (12),
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA     (ERR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_div       (clk_div),
    .host_req      (host_req),
    .host_rw       (host_rw),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .host_done     (host_done),
    .host_rdata    (host_rdata),
    .host_err      (host_err),
    .busy          (busy),
    .pio_start     (pio_start),
    .pio_rw        (pio_rw),
    .pio_addr_wdata(pio_addr_wdata),
    .pio_ack       (pio_ack),
    .pio_rvalid    (pio_rvalid),
    .pio_rdata     (pio_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          div;
    int          lat;
    bit          spur;
    int          exp_rel;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one transaction from an idle DUT. div: 0 = clk_div always 1,
  // k = every k-th cycle, 99 = random. lat: response cycles after the last
  // beat, -1 = never. Cycle n is observed and driven at its falling edge.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int div, input int lat, input bit spur,
                         output int done_rel, output logic [31:0] got_rd, output logic got_err);
    int          n, ph, exp_start, exp_data, resp_cyc, beats, exp_done;
    logic [31:0] exp_rd, exp_pad;
    logic        exp_err, cd;
    bit          resp_now;
    ph = 0; exp_start = -1; exp_data = -1; resp_cyc = -1; beats = 0; exp_done = -1;
    exp_rd = '0; exp_err = 1'b0; done_rel = -1; got_rd = '0; got_err = 1'b0;
    for (n = 0; n < BUDGET; n++) begin
      if (n > 0) @(negedge clk);
      exp_pad = (n == exp_start) ? addr : (n == exp_data) ? wd : 32'h0;
      chk1("host_gnt", host_gnt, n == 1);
      chk1("pio_start", pio_start, n == exp_start);
      chk1("pio_rw", pio_rw, (n == exp_start) && rw);
      chk32("pio_addr_wdata", pio_addr_wdata, exp_pad);
      chk1("host_done", host_done, n == exp_done);
      chk1("busy", busy, (n >= 2) && (exp_done < 0 || n <= exp_done));
      if (host_done) begin
        done_rel = n - 1;
        got_rd   = host_rdata;
        got_err  = host_err;
      end
      if (n == exp_done) begin
        chk32("host_rdata", host_rdata, exp_rd);
        chk1("host_err", host_err, exp_err);
      end
      if (exp_done >= 0 && n == exp_done + 1) begin
        chk32("rdata_hold", host_rdata, exp_rd);
        break;
      end
      host_req   = (n == 0);
      host_rw    = rw;
      host_addr  = addr;
      host_wdata = wd;
      if (div == 0) cd = 1'b1;
      else if (div == 99) cd = ($urandom_range(1, 0) == 1);
      else cd = ((n % div) == 0);
      clk_div    = cd;
      resp_now   = (ph == 3) && (n == resp_cyc);
      pio_ack    = 1'b0;
      pio_rvalid = 1'b0;
      pio_rdata  = $urandom;
      if (resp_now) begin
        if (rw) begin
          pio_rvalid = 1'b1;
          pio_rdata  = rd;
        end else begin
          pio_ack = 1'b1;
        end
      end
      if (spur) begin
        if (ph == 3) begin
          if (rw) pio_ack = 1'b1;
          else pio_rvalid = 1'b1;
        end else begin
          pio_ack    = ($urandom_range(1, 0) == 1);
          pio_rvalid = ($urandom_range(1, 0) == 1);
        end
      end
      case (ph)
        0: ph = 1;
        1: if (cd) begin
          exp_start = n + 1;
          if (rw) begin
            ph = 3;
            resp_cyc = (lat < 0) ? -1 : n + 1 + lat;
          end else begin
            ph = 2;
          end
        end
        2: if (cd) begin
          exp_data = n + 1;
          ph = 3;
          resp_cyc = (lat < 0) ? -1 : n + 1 + lat;
        end
        3: begin
          if (resp_now) begin
            exp_done = n + 1;
            exp_rd   = rw ? rd : 32'h0;
            exp_err  = 1'b0;
            ph = 4;
          end else if (cd) begin
            beats++;
            if (beats == TMO) begin
              exp_done = n + 1;
              exp_rd   = rw ? ERR : 32'h0;
              exp_err  = 1'b1;
              ph = 4;
            end
          end
        end
        default: ;
      endcase
    end
    chk1("txn_completes", n < BUDGET, 1'b1);
    host_req   = 1'b0;
    pio_ack    = 1'b0;
    pio_rvalid = 1'b0;
  endtask

  initial begin
    vec_t        vecs[12];
    int          rel;
    logic [31:0] grd;
    logic        gerr;
    logic        seen, got_done;
    int          gnts, dones, starts, viol, ack_at, last_done;
    bit          outst;

    //          rw    addr          wdata         rdata         div lat spur rel rdata         err
    vecs[0]  = '{1'b0, 32'h0001_0040, 32'h1234_5678, 32'h0,        0,  3,  0,  6, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'hFFFF_0001, 32'h0,        0,  1,  0,  4, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 32'h0002_0008, 32'h0,         32'hCAFE_F00D, 4,  2,  0,  7, 32'hCAFE_F00D, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0100, 32'h0,         32'h0000_0001, 0,  1,  0,  3, 32'h0000_0001, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0200, 32'h0,         32'h1111_2222, 0, -1,  0, 17, ERR,          1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0204, 32'h0,         32'h8765_4321, 0,  2,  0,  4, 32'h8765_4321, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0208, 32'h0,         32'h0F0F_0F0F, 0, 15,  1, 17, 32'h0F0F_0F0F, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_020C, 32'h0,         32'h3333_4444, 0, 16,  1, 17, ERR,          1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0300, 32'hABCD_0001, 32'h0,        0, -1,  0, 18, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0304, 32'hABCD_0002, 32'h0,        0, 15,  0, 18, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h0000_0308, 32'hABCD_0003, 32'h0,        3,  2,  1,  9, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h0000_030C, 32'h0,         32'h5555_AAAA, 0,  4,  1,  6, 32'h5555_AAAA, 1'b0};

    rst_n = 1'b0; clk_div = 1'b0; host_req = 1'b0; host_rw = 1'b0;
    host_addr = '0; host_wdata = '0; pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
    repeat (3) @(negedge clk);
    chk1("reset_outputs", |{host_gnt, host_done, host_rdata, host_err, busy,
                           pio_start, pio_rw, pio_addr_wdata}, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_reset_idle", |{host_gnt, host_done, host_rdata, host_err, busy,
                             pio_start, pio_rw, pio_addr_wdata}, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].div,
              vecs[i].lat, vecs[i].spur, rel, grd, gerr);
      chk32("vec_done_cycle", rel, vecs[i].exp_rel);
      chk32("vec_rdata", grd, vecs[i].exp_rd);
      chk1("vec_err", gerr, vecs[i].exp_err);
    end

    // Reset in the middle of a read wait aborts without a completion.
    host_req = 1'b1; host_rw = 1'b1; host_addr = 32'h0003_0010; clk_div = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (host_gnt) host_req = 1'b0;
      if (pio_start) seen = 1'b1;
    end
    chk1("rst_seq_start", seen, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("rst_async_clear", |{host_gnt, host_done, host_rdata, host_err, busy,
                             pio_start, pio_rw, pio_addr_wdata}, 1'b0);
    got_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      got_done = got_done | host_done;
    end
    chk1("rst_no_done", got_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 32'h0003_0014, 32'h0, 32'h1357_9BDF, 0, 2, 0, rel, grd, gerr);
    chk32("post_rst_done_cycle", rel, 4);
    chk32("post_rst_rdata", grd, 32'h1357_9BDF);
    chk1("post_rst_err", gerr, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int d, l;
      case ($urandom_range(3, 0))
        0: d = 0;
        1: d = 2;
        2: d = 3;
        default: d = 99;
      endcase
      l = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(20, 1));
      run_txn($urandom_range(1, 0) == 1, $urandom, $urandom, $urandom, d, l,
              $urandom_range(1, 0) == 1, rel, grd, gerr);
    end

    // Request held high across three writes.
    gnts = 0; dones = 0; starts = 0; viol = 0; ack_at = -1; last_done = -10; outst = 1'b0;
    host_req = 1'b1; host_rw = 1'b0; host_addr = 32'h0004_0000; host_wdata = 32'hA5A5_0000;
    clk_div = 1'b1; pio_rvalid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      pio_ack = 1'b0;
      if (host_gnt) begin
        gnts++;
        if (gnts > 1) chk32("b2b_gnt_cycle", n, last_done + 1);
        if (gnts == 3) host_req = 1'b0;
        host_addr  = host_addr + 4;
        host_wdata = host_wdata + 1;
      end
      if (pio_start) begin
        starts++;
        if (outst) viol++;
        outst  = 1'b1;
        ack_at = n + 2;
      end
      if (n == ack_at) pio_ack = 1'b1;
      if (host_done) begin
        dones++;
        outst     = 1'b0;
        last_done = n;
      end
    end
    pio_ack = 1'b0;
    chk32("b2b_gnt_count", gnts, 3);
    chk32("b2b_done_count", dones, 3);
    chk32("b2b_start_count", starts, 3);
    chk32("b2b_overlap", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_master.md
Name: pio_master

Overview:
- Initiator end of the PIO register-access bus. It converts single host register read/write requests into pio_start/pio_rw/pio_addr_wdata beats, waits for the responder's pio_ack (write) or pio_rvalid/pio_rdata (read), and returns completion to the host.
- Sits at the chip-level CPU/management bridge and fans out to every block's pio2reg_bus input.
- One transaction outstanding at a time, protected by a response timeout.

Parameters:
- PIO_NBITS, `PIO_NBITS (32): width of the shared address/data bus.
- TIMEOUT_NBITS, 12: width of the response-timeout counter.
- TIMEOUT_CYCLES, 2048: clk_div beats to wait for a response before flagging an error.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk  in  1  core clock
- `RESET_SIG  in  1  asynchronous active-low reset (rst_n)
- clk_div  in  1  bus beat enable; PIO outputs advance only in cycles where clk_div=1
- host_req  in  1  request valid; held until host_gnt
- host_rw  in  1  1=read, 0=write
- host_addr  in  PIO_NBITS  register/memory address
- host_wdata  in  PIO_NBITS  write data
- host_gnt  out  1  one-cycle request-accept pulse
- host_done  out  1  one-cycle completion pulse
- host_rdata  out  PIO_NBITS  read data, valid with host_done
- host_err  out  1  timeout flag, valid with host_done
- busy  out  1  transaction outstanding
- pio_start  out  1  first beat of a transaction
- pio_rw  out  1  1=read, 0=write; valid with pio_start
- pio_addr_wdata  out  PIO_NBITS  address on the start beat, write data on the next beat
- pio_ack  in  1  write-complete pulse (OR of all responders)
- pio_rvalid  in  1  read-data-valid pulse (OR of all responders)
- pio_rdata  in  PIO_NBITS  read data, valid with pio_rvalid

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0. Reset asserted mid-transaction aborts it with no host_done.
- FSM states: IDLE, ADDR, DATA, WAIT, DONE.
- IDLE:
  - On host_req=1, pulse host_gnt for one cycle and latch rw/addr/wdata.
  - Go to ADDR. busy=1 from the cycle after gnt until the cycle after host_done.
- ADDR:
  - On the first clk_div=1 cycle, drive pio_start=1, pio_rw=latched rw, pio_addr_wdata=addr for exactly that clk cycle.
  - Write: go to DATA. Read: go to WAIT.
- DATA (write only): on the next clk_div=1 cycle, drive pio_addr_wdata=wdata for that cycle, pio_start=0; go to WAIT.
- pio_addr_wdata, pio_rw and pio_start return to 0 in every cycle that is not a driven beat.
- WAIT:
  - The counter clears on entry and increments on each clk_div=1 cycle.
  - Write completes on pio_ack=1; read completes on pio_rvalid=1, which captures pio_rdata. Response inputs are sampled every clk cycle, independent of clk_div.
  - When the counter reaches TIMEOUT_CYCLES-1 on a clk_div beat with no response, complete with host_err=1 and host_rdata=ERR_RDATA for a read or 0 for a write.
  - Response and timeout in the same cycle: the response wins, host_err=0.
  - Go to DONE.
- DONE: host_done=1 for one cycle with host_rdata/host_err; return to IDLE.
  - host_rdata holds its value until the next host_done.
  - host_req held high back-to-back is granted in the cycle after DONE.
- Spurious responses:
  - pio_ack or pio_rvalid in IDLE/ADDR/DATA/DONE is ignored.
  - pio_ack during a read WAIT, or pio_rvalid during a write WAIT, is ignored; only the matching response completes the transaction.
- Minimum latency with clk_div tied to 1 and an immediate response (gnt = cycle 0, start = cycle 1):
  - Write: data beat cycle 2; ack sampled cycle 3; host_done cycle 4.
  - Read: rvalid sampled cycle 2; host_done cycle 3.

Decomposition:
- Shared package (meta_package or pio_package): typedef enum pio_mst_state_e {IDLE, ADDR, DATA, WAIT, DONE}; PIO_ERR_RDATA constant; `PIO_NBITS stays in defines.vh.
- One sub-module is natural: pio_timeout_cnt (clear / enable / expire), reusable by other initiators.

Test Plan:
- Write, clk_div=1: addr 0x0001_0040, wdata 0x1234_5678 → pio_start at cycle 1 with 0x0001_0040 and rw=0; 0x1234_5678 at cycle 2; pio_ack at cycle 5 → host_done cycle 6, host_err=0.
- Read, clk_div pulsing every 4th cycle: addr 0x0002_0008; pio_rvalid with rdata 0xCAFE_F00D → start beat only on a clk_div cycle; host_rdata=0xCAFE_F00D with host_done; no DATA beat.
- Timeout: read with no response, TIMEOUT_CYCLES=16 and clk_div=1 → host_done 16 beats after entering WAIT, host_err=1, host_rdata=0xDEAD_BEEF; the next read succeeds with host_err=0.
- Spurious and simultaneous events: pio_ack during a read WAIT is ignored; pio_rvalid arriving on the expiry beat → host_err=0 with the data captured.
- Back-to-back: host_req held for 3 writes → exactly 3 gnt and 3 done pulses, never two pio_start without an intervening done.
- Reset mid-WAIT: deassert rst_n → all outputs 0 immediately, no host_done; after release a new request proceeds normally.
